lsu_bus_arbiter: RTL
====================

LSU_BUS_ARBITER -- requirements
Module: lsu_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: maximum strobed cycles without ack/err before local abort; legal range 1..65535.
REQ-002 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port ld_req_i  input  1  load request; held high until ld_valid_o or ld_err_o.
REQ-005 The block SHALL have port ld_addr_i  input  32  load address.
REQ-006 The block SHALL have port ld_valid_o  output  1  one-cycle pulse, load completed.
REQ-007 The block SHALL have port ld_rdata_o  output  32  read data, meaningful only while ld_valid_o=1.
REQ-008 The block SHALL have port ld_err_o  output  1  one-cycle pulse, load failed (bus error or timeout).
REQ-009 The block SHALL have port st_req_i  input  1  store request; held high until st_valid_o or st_err_o.
REQ-010 The block SHALL have port st_addr_i  input  32  store address.
REQ-011 The block SHALL have port st_data_i  input  32  store data.
REQ-012 The block SHALL have port st_sel_i  input  4  store byte enables.
REQ-013 The block SHALL have port st_valid_o  output  1  one-cycle pulse, store completed.
REQ-014 The block SHALL have port st_err_o  output  1  one-cycle pulse, store failed.
REQ-015 The block SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-016 The block SHALL have port wb_bus  wb_master_bus_t  -  the single shared wishbone master port.

Function
REQ-017 States SHALL be IDLE, LOAD and STORE; IDLE SHALL drive wb_cyc_o=0, wb_stb_o=0 and wb_sel_o=0.
REQ-018 In IDLE, a single active request SHALL move the block to its state on the next edge.
REQ-019 With both requests active in IDLE, the grant SHALL go to the requester not served last (round robin); the last_grant register SHALL update on each grant.
REQ-020 In LOAD/STORE: wb_cyc_o=1; while wb_gnt_i=1, drive wb_stb_o=1, wb_adr_o from the granted address, and wb_we_o=1 only in STORE.
REQ-021 In LOAD/STORE, wb_sel_o SHALL be 4'b1111 for loads and st_sel_i for stores; wb_dat_o SHALL be st_data_i.
REQ-022 wb_ack_i while strobed SHALL pulse the granted requester's valid_o in the same cycle (combinational); ld_rdata_o SHALL equal wb_dat_i; next state SHALL be IDLE.
REQ-023 wb_err_i while strobed SHALL pulse the granted requester's err_o in the same cycle; next state SHALL be IDLE. If ack and err are both high, err SHALL win.
REQ-024 A timeout counter SHALL clear on every grant and increment each strobed cycle without ack/err; reaching TIMEOUT_CYCLES SHALL pulse err_o, go to IDLE and drop wb_cyc_o on the next edge.
REQ-025 The counter SHALL NOT advance while wb_gnt_i=0; arbitration-wait cycles SHALL be unbounded.
REQ-026 If the granted requester drops req before completion, the transaction SHALL be abandoned: no valid/err pulse, IDLE on the next edge.
REQ-027 Each transaction SHALL return to IDLE; consecutive transactions SHALL be separated by at least one IDLE cycle with wb_cyc_o=0.
REQ-028 The non-granted requester SHALL see valid_o=0 and err_o=0 at all times.
REQ-029 wb_lock_o, wb_tgc_o, wb_tgd_o and wb_tga_o SHALL be tied to 0.

Reset
REQ-030 rst_i=1 at a clock edge SHALL force IDLE, set last_grant=STORE (so load wins the first contention) and clear the timeout counter.
REQ-031 Reset SHALL apply even mid-transaction: wb_cyc_o and wb_stb_o SHALL be 0 in the cycle after the reset edge, with no valid/err pulse.
REQ-032 During and directly after reset, all outputs SHALL be 0.

Structure
REQ-033 A package lsu_arb_pkg SHALL hold the state enum (IDLE, LOAD, STORE) and the requester enum (REQ_LD, REQ_ST); wb_master_bus_t SHALL stay in the existing bus package.
REQ-034 The timeout counter SHALL be sub-module wb_watchdog (inputs: clear, count-enable; output: expired; parameter TIMEOUT_CYCLES).

Verification
REQ-035 Scenario: load only, addr 0x100, gnt=1, ack after 2 cycles with dat 0xDEADBEEF -> one ld_valid_o pulse with rdata 0xDEADBEEF, we=0, sel=1111, then IDLE.
REQ-036 Scenario: both requests from reset, acks immediate -> load served first, then store (we=1, sel=st_sel_i=0011), with one IDLE cycle between them.
REQ-037 Scenario: TIMEOUT_CYCLES=4, store with gnt=1 and no ack -> st_err_o pulses on the 4th strobed cycle; next cycle cyc=0.
REQ-038 Scenario: load with gnt=0 for 10 cycles, then gnt=1 and ack -> no timeout, ld_valid_o pulses once.
REQ-039 Scenario: wb_err_i and wb_ack_i high together on a store -> st_err_o=1, st_valid_o=0.
REQ-040 Scenario: rst_i asserted while strobed, or ld_req_i dropped before ack -> cyc=0 next cycle, no pulses, busy_o=0.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types for the LSU bus arbiter: FSM states, requester identities and
// the round-robin pick between the load and store ports.
package lsu_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int TAG_W  = 1;

    localparam logic [SEL_W-1:0] SEL_ALL = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_LD = 1'b0,
        REQ_ST = 1'b1
    } req_e;

    // On contention the requester that was not served last wins.
    function automatic req_e rr_pick(input logic ld, input logic st, input req_e last);
        if (ld && st) begin
            return (last == REQ_LD) ? REQ_ST : REQ_LD;
        end
        return st ? REQ_ST : REQ_LD;
    endfunction

endpackage

// File: rtl/lsu_bus_arbiter_if.sv
// Wishbone master bus shared by the load and store ports; the arbiter is the
// master, the interconnect/slave side uses the slave modport.
interface lsu_bus_arbiter_if;

    logic                              wb_cyc_o;
    logic                              wb_stb_o;
    logic                              wb_we_o;
    logic [lsu_arb_pkg::ADDR_W-1:0]    wb_adr_o;
    logic [lsu_arb_pkg::SEL_W-1:0]     wb_sel_o;
    logic [lsu_arb_pkg::DATA_W-1:0]    wb_dat_o;
    logic                              wb_lock_o;
    logic [lsu_arb_pkg::TAG_W-1:0]     wb_tgc_o;
    logic [lsu_arb_pkg::TAG_W-1:0]     wb_tgd_o;
    logic [lsu_arb_pkg::TAG_W-1:0]     wb_tga_o;
    logic [lsu_arb_pkg::DATA_W-1:0]    wb_dat_i;
    logic                              wb_ack_i;
    logic                              wb_err_i;
    logic                              wb_gnt_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
               wb_lock_o, wb_tgc_o, wb_tgd_o, wb_tga_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_gnt_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
               wb_lock_o, wb_tgc_o, wb_tgd_o, wb_tga_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_gnt_i
    );

endinterface

// File: rtl/wb_watchdog.sv
// Counts strobed bus cycles that see neither ack nor err; flags the cycle in
// which the TIMEOUT_CYCLES-th such cycle is being spent.
module wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the strobed cycles already spent, so this one is number cnt_q+1.
    assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/lsu_bus_arbiter.sv
// Arbitrates the LSU load and store ports onto one wishbone master, one
// transaction at a time, round robin on contention, with a strobe watchdog.
module lsu_bus_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  ld_req_i,
    input  logic [ADDR_W-1:0]     ld_addr_i,
    output logic                  ld_valid_o,
    output logic [DATA_W-1:0]     ld_rdata_o,
    output logic                  ld_err_o,
    input  logic                  st_req_i,
    input  logic [ADDR_W-1:0]     st_addr_i,
    input  logic [DATA_W-1:0]     st_data_i,
    input  logic [SEL_W-1:0]      st_sel_i,
    output logic                  st_valid_o,
    output logic                  st_err_o,
    output logic                  busy_o,
    lsu_bus_arbiter_if.master     wb_bus
);

    arb_state_e state_q;
    arb_state_e state_d;
    req_e       last_grant_q;
    req_e       last_grant_d;

    logic req_held;
    logic strobed;
    logic grant;
    logic wd_en;
    logic wd_expired;
    logic cmpl_ok;
    logic cmpl_err;

    assign req_held = (state_q == LOAD)  ? ld_req_i :
                      (state_q == STORE) ? st_req_i : 1'b0;
    assign strobed  = (state_q != IDLE) && wb_bus.wb_gnt_i;
    assign grant    = (state_q == IDLE) && (ld_req_i || st_req_i);

    // A dropped request abandons the transaction, so nothing completes without it.
    assign wd_en    = strobed && req_held && !wb_bus.wb_ack_i && !wb_bus.wb_err_i;
    assign cmpl_err = strobed && req_held && (wb_bus.wb_err_i || wd_expired);
    assign cmpl_ok  = strobed && req_held && wb_bus.wb_ack_i && !wb_bus.wb_err_i;

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_i     (rst_i),
        .clr_i     (grant),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_ST;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    last_grant_d = rr_pick(ld_req_i, st_req_i, last_grant_q);
                    state_d      = (last_grant_d == REQ_ST) ? STORE : LOAD;
                end
            end
            LOAD, STORE: begin
                if (!req_held || cmpl_ok || cmpl_err) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks every output combinationally so nothing leaks in the reset cycle.
    always_comb begin
        busy_o          = 1'b0;
        wb_bus.wb_cyc_o = 1'b0;
        wb_bus.wb_stb_o = 1'b0;
        wb_bus.wb_we_o  = 1'b0;
        wb_bus.wb_adr_o = '0;
        wb_bus.wb_sel_o = '0;
        wb_bus.wb_dat_o = '0;
        ld_valid_o      = 1'b0;
        ld_err_o        = 1'b0;
        ld_rdata_o      = '0;
        st_valid_o      = 1'b0;
        st_err_o        = 1'b0;
        if (!rst_i && (state_q != IDLE)) begin
            busy_o          = 1'b1;
            wb_bus.wb_cyc_o = 1'b1;
            wb_bus.wb_dat_o = st_data_i;
            wb_bus.wb_sel_o = (state_q == STORE) ? st_sel_i : SEL_ALL;
            if (wb_bus.wb_gnt_i) begin
                wb_bus.wb_stb_o = 1'b1;
                wb_bus.wb_we_o  = (state_q == STORE);
                wb_bus.wb_adr_o = (state_q == STORE) ? st_addr_i : ld_addr_i;
            end
            if (state_q == LOAD) begin
                ld_valid_o = cmpl_ok;
                ld_err_o   = cmpl_err;
                if (cmpl_ok) begin
                    ld_rdata_o = wb_bus.wb_dat_i;
                end
            end else begin
                st_valid_o = cmpl_ok;
                st_err_o   = cmpl_err;
            end
        end
    end

    assign wb_bus.wb_lock_o = 1'b0;
    assign wb_bus.wb_tgc_o  = '0;
    assign wb_bus.wb_tgd_o  = '0;
    assign wb_bus.wb_tga_o  = '0;

endmodule
